// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//
// Penalty shoot-out referee. Counts alternating player/enemy shots, keeps
// both scores and decides the winner once the match is settled. The score
// outputs feed the score text ROM directly, so they stay within 0..5.
//
// Parameters
//   SHOTS_PER_SIDE  regulation shots per side (1..5)
//
// Optional feature macro
//   EARLY_FINISH_EN  when defined, the match ends as soon as one side can no
//                    longer be caught; otherwise every side takes all shots.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start_game    in   1-cycle pulse: clear everything and start a match
//   shot_valid    in   1-cycle pulse: a shot has finished
//   shot_goal     in   qualifies shot_valid: 1 = goal, 0 = saved/missed
//   score_player  out  player goals
//   score_enemy   out  enemy goals
//   shots_player  out  player shots taken
//   shots_enemy   out  enemy shots taken
//   shooter       out  side due to shoot: 0 = player, 1 = enemy
//   game_over     out  high while the result is shown
//   result        out  00 none, 01 player win, 10 enemy win, 11 draw
// ---------------------------------------------------------------------------
module score_keeper #(
  parameter int SHOTS_PER_SIDE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       shot_valid,
  input  logic       shot_goal,
  output logic [2:0] score_player,
  output logic [2:0] score_enemy,
  output logic [2:0] shots_player,
  output logic [2:0] shots_enemy,
  output logic       shooter,
  output logic       game_over,
  output logic [1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    PLAYER_SHOT,
    ENEMY_SHOT,
    RESULT
  } state_t;

  localparam logic [2:0] SHOTS_N3 = 3'(SHOTS_PER_SIDE);

  state_t     state_q, state_d;
  logic [2:0] score_player_q, score_player_d;
  logic [2:0] score_enemy_q,  score_enemy_d;
  logic [2:0] shots_player_q, shots_player_d;
  logic [2:0] shots_enemy_q,  shots_enemy_d;
  logic [1:0] result_q,       result_d;

  // Final verdict once both sides have taken all their shots.
  function automatic logic [1:0] final_code(input logic [2:0] sp,
                                            input logic [2:0] se);
    if (sp > se)      final_code = 2'b01;
    else if (sp < se) final_code = 2'b10;
    else              final_code = 2'b11;
  endfunction

`ifdef EARLY_FINISH_EN
  localparam logic [3:0] SHOTS_N4 = 4'(SHOTS_PER_SIDE);

  logic [1:0] early_code;

  // A side has won early when its score beats the best score the other side
  // could still reach with its remaining shots. A draw is never early.
  function automatic logic [1:0] early_decision(input logic [2:0] sp,
                                                input logic [2:0] se,
                                                input logic [2:0] shp,
                                                input logic [2:0] she);
    logic [3:0] player_reach;
    logic [3:0] enemy_reach;
    player_reach = {1'b0, sp} + (SHOTS_N4 - {1'b0, shp});
    enemy_reach  = {1'b0, se} + (SHOTS_N4 - {1'b0, she});
    if ({1'b0, sp} > enemy_reach)      early_decision = 2'b01;
    else if ({1'b0, se} > player_reach) early_decision = 2'b10;
    else                                early_decision = 2'b00;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      score_player_q <= '0;
      score_enemy_q  <= '0;
      shots_player_q <= '0;
      shots_enemy_q  <= '0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      score_player_q <= score_player_d;
      score_enemy_q  <= score_enemy_d;
      shots_player_q <= shots_player_d;
      shots_enemy_q  <= shots_enemy_d;
      result_q       <= result_d;
    end
  end

  // start_game has priority over everything, including a shot in the same
  // cycle. Shots outside the two shooting states are dropped. The verdict is
  // computed from the post-shot values so it lands on the same edge.
  always_comb begin
    state_d        = state_q;
    score_player_d = score_player_q;
    score_enemy_d  = score_enemy_q;
    shots_player_d = shots_player_q;
    shots_enemy_d  = shots_enemy_q;
    result_d       = result_q;
`ifdef EARLY_FINISH_EN
    early_code     = 2'b00;
`endif

    if (start_game) begin
      state_d        = PLAYER_SHOT;
      score_player_d = '0;
      score_enemy_d  = '0;
      shots_player_d = '0;
      shots_enemy_d  = '0;
      result_d       = '0;
    end else begin
      case (state_q)
        PLAYER_SHOT: begin
          if (shot_valid) begin
            shots_player_d = shots_player_q + 3'd1;
            score_player_d = score_player_q + {2'b00, shot_goal};
            state_d        = ENEMY_SHOT;
`ifdef EARLY_FINISH_EN
            early_code = early_decision(score_player_d, score_enemy_q,
                                        shots_player_d, shots_enemy_q);
            if (early_code != 2'b00) begin
              state_d  = RESULT;
              result_d = early_code;
            end
`endif
          end
        end
        ENEMY_SHOT: begin
          if (shot_valid) begin
            shots_enemy_d = shots_enemy_q + 3'd1;
            score_enemy_d = score_enemy_q + {2'b00, shot_goal};
            if (shots_enemy_d == SHOTS_N3) begin
              state_d  = RESULT;
              result_d = final_code(score_player_q, score_enemy_d);
            end else begin
              state_d = PLAYER_SHOT;
`ifdef EARLY_FINISH_EN
              early_code = early_decision(score_player_q, score_enemy_d,
                                          shots_player_q, shots_enemy_d);
              if (early_code != 2'b00) begin
                state_d  = RESULT;
                result_d = early_code;
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign score_player = score_player_q;
  assign score_enemy  = score_enemy_q;
  assign shots_player = shots_player_q;
  assign shots_enemy  = shots_enemy_q;
  assign result       = result_q;
  assign shooter      = (state_q == ENEMY_SHOT);
  assign game_over    = (state_q == RESULT);

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_game;
  logic       shot_valid;
  logic       shot_goal;
  logic [2:0] score_player;
  logic [2:0] score_enemy;
  logic [2:0] shots_player;
  logic [2:0] shots_enemy;
  logic       shooter;
  logic       game_over;
  logic [1:0] result;

  int checks = 0;
  int errors = 0;

  // Reference model: a shoot-out described as scores and shot counts.
  int m_sp, m_se, m_ps, m_es, m_res;
  bit m_active, m_over;

  score_keeper #(.SHOTS_PER_SIDE(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_game   (start_game),
    .shot_valid   (shot_valid),
    .shot_goal    (shot_goal),
    .score_player (score_player),
    .score_enemy  (score_enemy),
    .shots_player (shots_player),
    .shots_enemy  (shots_enemy),
    .shooter      (shooter),
    .game_over    (game_over),
    .result       (result)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_out;
  assign dut_out = {score_player, score_enemy, shots_player, shots_enemy,
                    shooter, game_over, result};

  function automatic logic [15:0] model_out();
    logic       exp_shooter;
    logic [1:0] exp_res;
    exp_shooter = m_active && !m_over && (m_ps > m_es);
    exp_res     = m_over ? 2'(m_res) : 2'b00;
    return {3'(m_sp), 3'(m_se), 3'(m_ps), 3'(m_es), exp_shooter, m_over, exp_res};
  endfunction

  task automatic model_reset();
    m_sp = 0; m_se = 0; m_ps = 0; m_es = 0; m_res = 0;
    m_active = 0; m_over = 0;
  endtask

  task automatic model_edge(input bit st, input bit sv, input bit sg);
    if (st) begin
      model_reset();
      m_active = 1;
    end else if (sv && m_active && !m_over) begin
      if (m_ps == m_es) begin
        m_ps++; m_sp += int'(sg);
      end else begin
        m_es++; m_se += int'(sg);
      end
      if (m_es == N) begin
        m_res = (m_sp > m_se) ? 1 : (m_sp < m_se) ? 2 : 3;
      end
`ifdef EARLY_FINISH_EN
      else if (m_sp > m_se + (N - m_es)) m_res = 1;
      else if (m_se > m_sp + (N - m_ps)) m_res = 2;
`endif
      if (m_res != 0) m_over = 1;
    end
  endtask

  // One clock cycle: drive at negedge, model the posedge, settle 1 time unit.
  task automatic drive(input bit st, input bit sv, input bit sg);
    @(negedge clk);
    start_game = st; shot_valid = sv; shot_goal = sg;
    @(posedge clk);
    model_edge(st, sv, sg);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0);
    drive(0, 1, 1);
    drive(0, 1, 1);
    drive(0, 1, 1);
    checks++;
    if (score_player !== 3'd2 || score_enemy !== 3'd1) begin
      errors++;
      $display("[TB] FAIL pre_reset_score: got %0d:%0d expected 2:1", score_player, score_enemy);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected 0000", dut_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1);
      checks++;
      if (dut_out !== 16'h0000 || dut_out !== model_out()) begin
        errors++;
        $display("[TB] FAIL idle_ignores_shot: got %h expected %h", dut_out, model_out());
      end
    end
  endtask

  task automatic test_player_sweep();
    drive(1, 0, 0);
    for (int i = 0; i < 2 * N; i++) begin
      drive(0, 1, (i % 2) == 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("[TB] FAIL sweep_shot%0d: got %h expected %h", i, dut_out, model_out());
      end
    end
`ifndef EARLY_FINISH_EN
    checks++;
    if ({score_player, score_enemy, shots_player, shots_enemy, game_over, result}
        !== {3'd5, 3'd0, 3'd5, 3'd5, 1'b1, 2'b01}) begin
      errors++;
      $display("[TB] FAIL sweep_final: got %0d:%0d shots %0d/%0d over %b res %b expected 5:0 5/5 1 01",
               score_player, score_enemy, shots_player, shots_enemy, game_over, result);
    end
`endif
  endtask

  task automatic test_draw();
    drive(1, 0, 0);
    for (int i = 0; i < 2 * N; i++) begin
      drive(0, 1, 1);
      checks++;
      if (dut_out !== model_out() || (i < 2 * N - 1 && shooter !== ((i % 2) == 0))) begin
        errors++;
        $display("[TB] FAIL draw_shot%0d: got %h expected %h", i, dut_out, model_out());
      end
    end
    checks++;
    if (score_player !== 3'd5 || score_enemy !== 3'd5 || result !== 2'b11 || game_over !== 1'b1) begin
      errors++;
      $display("[TB] FAIL draw_final: got %0d:%0d res %b over %b expected 5:5 11 1",
               score_player, score_enemy, result, game_over);
    end
  endtask

  task automatic test_early_finish();
    drive(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, (i % 2) == 0);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("[TB] FAIL early_shot%0d: got %h expected %h", i, dut_out, model_out());
      end
    end
`ifdef EARLY_FINISH_EN
    checks++;
    if ({score_player, score_enemy, shots_player, shots_enemy, game_over, result}
        !== {3'd3, 3'd0, 3'd3, 3'd3, 1'b1, 2'b01}) begin
      errors++;
      $display("[TB] FAIL early_final: got %h expected 3:0 3/3 over 01", dut_out);
    end
`else
    checks++;
    if (game_over !== 1'b0 || shooter !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_early_finish: got over %b shooter %b expected 0 0", game_over, shooter);
    end
`endif
  endtask

  task automatic test_start_priority();
    logic [15:0] saved;
    drive(1, 1, 1);
    checks++;
    if (shots_player !== 3'd0 || score_player !== 3'd0 || shooter !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_beats_shot: got shots %0d score %0d shooter %b expected 0 0 0",
               shots_player, score_player, shooter);
    end
    drive(0, 1, 0);
    checks++;
    if (shots_player !== 3'd1 || shooter !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_shot_after_start: got shots %0d shooter %b expected 1 1",
               shots_player, shooter);
    end
    for (int i = 1; i < 2 * N; i++) drive(0, 1, 0);
    saved = dut_out;
    checks++;
    if (saved !== 16'({3'd0, 3'd0, 3'd5, 3'd5, 1'b0, 1'b1, 2'b11})) begin
      errors++;
      $display("[TB] FAIL miss_draw: got %h expected %h", saved,
               16'({3'd0, 3'd0, 3'd5, 3'd5, 1'b0, 1'b1, 2'b11}));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1);
      checks++;
      if (dut_out !== saved) begin
        errors++;
        $display("[TB] FAIL result_ignores_shot: got %h expected %h", dut_out, saved);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 1);
    checks++;
    if ({score_player, score_enemy, shots_player, shots_enemy} !== {3'd2, 3'd2, 3'd2, 3'd2}
        || dut_out !== model_out()) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %h expected 2:2 2/2 (%h)", dut_out, model_out());
    end
  endtask

  task automatic test_random();
    bit st, sv, sg;
    for (int m = 0; m < 8; m++) begin
      drive(1, 0, 0);
      for (int c = 0; c < 16; c++) begin
        st = ($urandom_range(0, 24) == 0);
        sv = ($urandom_range(0, 3) != 0);
        sg = $urandom_range(0, 1);
        drive(st, sv, sg);
        checks++;
        if (dut_out !== model_out()) begin
          errors++;
          $display("[TB] FAIL random_m%0d_c%0d: got %h expected %h", m, c, dut_out, model_out());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_game = 1'b0; shot_valid = 1'b0; shot_goal = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL power_on_reset: got %h expected 0000", dut_out);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_player_sweep();
    test_draw();
    test_early_finish();
    test_start_priority();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
